iter_divider: RTL

- Multi-cycle iterative integer divider. Produces quotient and remainder for signed or unsigned operands, selected per operation.
- Successor to the single-expression combinational divide helper. Adds:
  - parametrised width and radix (steps per cycle)
  - valid/ready handshakes on both sides
  - defined divide-by-zero and signed-overflow results
- Sits beside the ALU datapath. Accepts one operation at a time.

---
 rtl/iter_divider.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider (signed/unsigned) with valid/ready on both sides.
// Optional synchronous flush input enabled by defining ITER_DIVIDER_FLUSH_EN.
module iter_divider #(
  parameter int WIDTH = 8,
  parameter int STEPS = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
`ifdef ITER_DIVIDER_FLUSH_EN
  input  logic             i_flush,
`endif
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  localparam int N  = WIDTH / STEPS;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0]    LAST_CNT = CW'(N - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
  logic             neg_quo_q, neg_rem_q, dbz_q;
  logic             ready_q, valid_q, div_by_zero_q;
  logic [WIDTH-1:0] quotient_q, remainder_q;

  logic [WIDTH-1:0] quo_d, rem_d;
  logic [WIDTH:0]   trial_d;
  logic             dvd_neg_d, dvs_neg_d, zero_d, ovf_d, flush_d;
  logic [WIDTH-1:0] dvd_mag_d, dvs_mag_d;

  function automatic logic [WIDTH-1:0] neg_if(input logic neg, input logic [WIDTH-1:0] v);
    if (neg) begin
      return ~v + ONE;
    end else begin
      return v;
    end
  endfunction

`ifdef ITER_DIVIDER_FLUSH_EN
  assign flush_d = i_flush;
`else
  assign flush_d = 1'b0;
`endif

  // Request decode: magnitudes, sign flags and the two special-result cases.
  always_comb begin
    dvd_neg_d = i_signed & i_dividend[WIDTH-1];
    dvs_neg_d = i_signed & i_divisor[WIDTH-1];
    dvd_mag_d = neg_if(dvd_neg_d, i_dividend);
    dvs_mag_d = neg_if(dvs_neg_d, i_divisor);
    zero_d    = (i_divisor == {WIDTH{1'b0}});
    ovf_d     = i_signed && (i_dividend == MIN_NEG) && (i_divisor == ALL_ONES);
  end

  // STEPS restoring shift/compare/subtract iterations on the magnitudes.
  always_comb begin
    quo_d   = quo_q;
    rem_d   = rem_q;
    trial_d = {(WIDTH+1){1'b0}};
    for (int k = 0; k < STEPS; k++) begin
      trial_d = {rem_d, quo_d[WIDTH-1]};
      quo_d   = {quo_d[WIDTH-2:0], 1'b0};
      if (trial_d >= {1'b0, dvs_q}) begin
        trial_d  = trial_d - {1'b0, dvs_q};
        quo_d[0] = 1'b1;
      end else begin
        quo_d[0] = 1'b0;
      end
      rem_d = trial_d[WIDTH-1:0];
    end
  end

  // Control FSM and output registers; special results finish through FIX too.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= {CW{1'b0}};
      quo_q         <= {WIDTH{1'b0}};
      rem_q         <= {WIDTH{1'b0}};
      dvs_q         <= {WIDTH{1'b0}};
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      dbz_q         <= 1'b0;
      ready_q       <= 1'b1;
      valid_q       <= 1'b0;
      div_by_zero_q <= 1'b0;
      quotient_q    <= {WIDTH{1'b0}};
      remainder_q   <= {WIDTH{1'b0}};
    end else if (flush_d) begin
      state_q       <= S_IDLE;
      cnt_q         <= {CW{1'b0}};
      ready_q       <= 1'b1;
      valid_q       <= 1'b0;
      div_by_zero_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_valid) begin
            ready_q <= 1'b0;
            cnt_q   <= {CW{1'b0}};
            if (zero_d) begin
              quo_q     <= ALL_ONES;
              rem_q     <= i_dividend;
              neg_quo_q <= 1'b0;
              neg_rem_q <= 1'b0;
              dbz_q     <= 1'b1;
              state_q   <= S_FIX;
            end else if (ovf_d) begin
              quo_q     <= i_dividend;
              rem_q     <= {WIDTH{1'b0}};
              neg_quo_q <= 1'b0;
              neg_rem_q <= 1'b0;
              dbz_q     <= 1'b0;
              state_q   <= S_FIX;
            end else begin
              quo_q     <= dvd_mag_d;
              rem_q     <= {WIDTH{1'b0}};
              dvs_q     <= dvs_mag_d;
              neg_quo_q <= dvd_neg_d ^ dvs_neg_d;
              neg_rem_q <= dvd_neg_d;
              dbz_q     <= 1'b0;
              state_q   <= S_CALC;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_CALC: begin
          quo_q <= quo_d;
          rem_q <= rem_d;
          if (cnt_q == LAST_CNT) begin
            cnt_q   <= {CW{1'b0}};
            state_q <= S_FIX;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_FIX: begin
          quotient_q    <= neg_if(neg_quo_q, quo_q);
          remainder_q   <= neg_if(neg_rem_q, rem_q);
          div_by_zero_q <= dbz_q;
          valid_q       <= 1'b1;
          state_q       <= S_DONE;
        end
        S_DONE: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready       = ready_q;
  assign o_valid       = valid_q;
  assign o_quotient    = quotient_q;
  assign o_remainder   = remainder_q;
  assign o_div_by_zero = div_by_zero_q;

endmodule
